fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch stage with a prefetch queue, for the WISC-V pipeline. It holds the fetch PC and reads a synchronous, bootloader-writable instruction memory. Fetched {PC, instruction} pairs are buffered in a QDEPTH-entry queue that drains to the IF/ID register through a valid/ready handshake. A redirect (branch, jump or misprediction resolution) flushes the queue and drops the in-flight read.

## Interface
Parameters:
- XLEN, 32, PC and instruction width
- IMEM_AW, 13, instruction memory word-address width (2^IMEM_AW words)
- QDEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC
- out_ready  in  1  IF/ID can accept an entry
- out_valid  out  1  queue head valid
- out_pc  out  XLEN  PC of head entry
- out_pc_plus4  out  XLEN  out_pc + 4 (modulo 2^XLEN)
- out_instr  out  XLEN  instruction of head entry
- out_ecall  out  1  out_valid && out_instr == 32'h00000073
- debug  in  1  boot mode: fetch issue halted, memory writes enabled
- boot_we  in  1  memory write strobe, honoured only when debug=1
- boot_addr  in  IMEM_AW  word address for boot write
- boot_data  in  XLEN  boot write data
- q_count  out  $clog2(QDEPTH)+1  occupied queue entries

## Operation
- Reset values: fetch_pc=RESET_PC, queue empty, inflight=0, out_valid=0, out_pc=0, out_pc_plus4=4, out_instr=0, out_ecall=0, q_count=0. Memory contents are not reset.
- Memory address is fetch_pc[IMEM_AW+1:2]. PC bits [1:0] are ignored, and bits above IMEM_AW+1 alias (wrap-around).
- Issue condition: !debug && !redirect_valid && (q_count + inflight − pop) < QDEPTH, where pop = out_valid && out_ready.
- On issue: the memory read is registered, inflight←1, inflight_pc←fetch_pc, and fetch_pc←fetch_pc+4.
- An issued read completes the following cycle. The entry {inflight_pc, rdata} is pushed that edge unless it has been killed.
- Push and pop in the same cycle are both performed. q_count is unchanged.
- Full: no issue, so an in-flight read always has a free slot. Empty: out_valid=0 and out_* hold their last values.
- Redirect (redirect_valid=1):
  - The queue is cleared, inflight←0 (the pending read result is discarded), and fetch_pc←redirect_pc. There is no issue this cycle.
  - A pop in the same cycle still counts as consumed by IF/ID.
  - Redirect has priority over push, pop and issue.
- Debug:
  - Issue stops; the queue and the in-flight read still drain normally.
  - Boot write: on posedge with debug && boot_we, mem[boot_addr]←boot_data.
  - A read and a write to the same address in the same cycle returns the old data.
  - Leaving debug does not change fetch_pc. Software issues a redirect to restart.
- Asynchronous reset mid-operation discards the queue and the in-flight read immediately.

## Timing
- Issue→available latency: 2 edges. The read is captured at edge N, the entry is pushed at N+1, and out_valid is high after N+1.
- After rst_n rises, the first posedge issues RESET_PC. out_valid rises after the second posedge.
- Redirect at edge R: issue of redirect_pc at R+1, out_valid for redirect_pc after R+2. Minimum redirect bubble is 2 cycles.
- With out_ready held high, steady-state throughput is 1 entry/cycle for any QDEPTH≥2.
- With out_ready held low: q_count saturates at QDEPTH, and fetch_pc stops at the first unissued address.

## Structure
- Package fetch_pkg:
  - fetch_entry_t struct {pc, instr}
  - ECALL_INSTR = 32'h00000073
  - PC_STEP = 4
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop and flush.
  - Head visible combinationally; count output.
  - Parametrised by QDEPTH.
- Top level holds fetch_pc, the inflight/kill logic, the memory array and the boot-write port.

## Test plan
- Reset with RESET_PC=0 and hex file mem[0..3]=A0,A1,A2,A3, out_ready=1 → out_valid after edge 2, then out_pc 0,4,8,12 on consecutive cycles with instr A0..A3 and out_pc_plus4 = out_pc+4.
- out_ready=0 for 10 cycles, QDEPTH=4 → q_count=4 and fetch_pc=16. Release → PCs 0,4,8,12,16 in order with no gaps or duplicates.
- Redirect to 0x40 while q_count=3 and a read is in flight → q_count=0 next cycle, and the next out_pc is 0x40 exactly 2 cycles later. No stale entry appears.
- Redirect coincident with a pop of PC 0x8 → the 0x8 handshake completes and the following out_pc is the redirect target.
- debug=1, boot_we writes 32'h00000073 at word 5, then debug=0 and redirect to 0x14 → out_ecall=1 with out_pc=0x14. A boot_we with debug=0 leaves memory unchanged.
- Assert rst_n low while q_count=2 → all outputs take reset values asynchronously, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC-V instruction-fetch stage.
package fetch_pkg;

   localparam int          PKG_XLEN    = 32;
   localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
   localparam logic [31:0] PC_STEP     = 32'd4;

   // One prefetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [PKG_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Prefetch queue: circular buffer of fetch entries with flush, head shown
// combinationally so IF/ID sees the oldest entry without an extra cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  fetch_entry_t            push_entry,
   output fetch_entry_t            head,
   output logic                    head_valid,
   output logic [$clog2(QDEPTH):0] count
);

   localparam int PW = $clog2(QDEPTH);

   fetch_entry_t     store_reg [QDEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;

   // Pointers and occupancy; flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage: each slot loads only when it is the write target.
   for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
      // Capture the pushed entry into this slot.
      always_ff @(posedge clk) begin
         if (push && !flush && (wr_ptr_reg == PW'(gi)))
            store_reg[gi] <= push_entry;
      end
   end

   assign head       = store_reg[rd_ptr_reg];
   assign head_valid = (count_reg != '0);
   assign count      = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: fetch PC, synchronous instruction memory with a
// boot-write port, one outstanding read, and a prefetch queue toward IF/ID.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              IMEM_AW  = 13,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [XLEN-1:0]           out_pc,
   output logic [XLEN-1:0]           out_pc_plus4,
   output logic [XLEN-1:0]           out_instr,
   output logic                      out_ecall,
   input  logic                      debug,
   input  logic                      boot_we,
   input  logic [IMEM_AW-1:0]        boot_addr,
   input  logic [XLEN-1:0]           boot_data,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [XLEN-1:0]    mem [2**IMEM_AW];
   logic [XLEN-1:0]    fetch_pc_reg;
   logic [XLEN-1:0]    inflight_pc_reg;
   logic               inflight_reg;
   logic [XLEN-1:0]    rdata_reg;
   logic [XLEN-1:0]    hold_pc_reg;
   logic [XLEN-1:0]    hold_instr_reg;

   logic               issue;
   logic               pop;
   logic               push;
   logic [CW:0]        occupancy;
   logic [IMEM_AW-1:0] mem_addr;
   fetch_entry_t       head;
   fetch_entry_t       push_entry;
   logic               head_valid;
   logic [CW-1:0]      count;

   // Slots committed after this edge: queued + outstanding - leaving.
   // Issuing only below QDEPTH guarantees the read always finds room.
   assign pop       = head_valid && out_ready;
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
   assign issue     = !debug && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
   assign push      = inflight_reg && !redirect_valid;
   assign mem_addr  = fetch_pc_reg[IMEM_AW+1:2];

   assign push_entry.pc    = inflight_pc_reg;
   assign push_entry.instr = rdata_reg;

   // Fetch PC and the single outstanding read; redirect kills the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg    <= RESET_PC;
         inflight_pc_reg <= '0;
         inflight_reg    <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc;
         end else if (issue) begin
            fetch_pc_reg    <= fetch_pc_reg + XLEN'(PC_STEP);
            inflight_pc_reg <= fetch_pc_reg;
         end
      end
   end

   // Instruction memory: registered read-first port plus debug-only writes.
   always_ff @(posedge clk) begin
      if (debug && boot_we)
         mem[boot_addr] <= boot_data;
      if (issue)
         rdata_reg <= mem[mem_addr];
   end

   // Remember the last head shown so outputs hold steady while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_pc_reg    <= '0;
         hold_instr_reg <= '0;
      end else if (head_valid) begin
         hold_pc_reg    <= head.pc;
         hold_instr_reg <= head.instr;
      end
   end

   fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .head       (head),
      .head_valid (head_valid),
      .count      (count)
   );

   assign out_valid    = head_valid;
   assign out_pc       = head_valid ? head.pc    : hold_pc_reg;
   assign out_instr    = head_valid ? head.instr : hold_instr_reg;
   assign out_pc_plus4 = out_pc + XLEN'(PC_STEP);
   assign out_ecall    = head_valid && (head.instr == ECALL_INSTR);
   assign q_count      = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed and randomized checks of fetch_queue_unit against a queue-based
// reference model of the fetch stage.
module tb_fetch_queue_unit;

   localparam int QDEPTH  = 4;
   localparam int IMEM_AW = 13;
   localparam int NWORDS  = 2**IMEM_AW;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               out_ready;
   logic               out_valid;
   logic [31:0]        out_pc;
   logic [31:0]        out_pc_plus4;
   logic [31:0]        out_instr;
   logic               out_ecall;
   logic               debug;
   logic               boot_we;
   logic [IMEM_AW-1:0] boot_addr;
   logic [31:0]        boot_data;
   logic [2:0]         q_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: queue contents, one pending read, fetch PC, memory.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   bit          pend_v;
   ent_t        pend;
   logic [31:0] m_fpc;
   logic [31:0] last_pc;
   logic [31:0] last_instr;
   logic [31:0] mmem [NWORDS];

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .XLEN(32), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .out_ecall(out_ecall),
      .debug(debug), .boot_we(boot_we), .boot_addr(boot_addr),
      .boot_data(boot_data), .q_count(q_count)
   );

   function automatic int widx(logic [31:0] pc);
      return int'((pc >> 2) & (NWORDS - 1));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      pend_v     = 0;
      m_fpc      = 32'h0;
      last_pc    = 32'h0;
      last_instr = 32'h0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      bit popv;
      int occ;
      popv = (mq.size() > 0) && out_ready;
      if (mq.size() > 0) begin
         last_pc    = mq[0].pc;
         last_instr = mq[0].instr;
         if (popv)
            $display("pop pc=%h instr=%h redirect=%0d", mq[0].pc, mq[0].instr, redirect_valid);
      end
      if (redirect_valid) begin
         mq.delete();
         pend_v = 0;
         m_fpc  = redirect_pc;
      end else begin
         occ = mq.size() + int'(pend_v) - int'(popv);
         if (popv) void'(mq.pop_front());
         if (pend_v) mq.push_back(pend);
         pend_v = 0;
         if (!debug && occ < QDEPTH) begin
            pend_v     = 1;
            pend.pc    = m_fpc;
            pend.instr = mmem[widx(m_fpc)];
            m_fpc      = m_fpc + 32'd4;
         end
      end
      if (debug && boot_we) mmem[boot_addr] = boot_data;
   endtask

   task automatic compare_all();
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ein;
      ev  = (mq.size() > 0);
      epc = ev ? mq[0].pc    : last_pc;
      ein = ev ? mq[0].instr : last_instr;
      chk("out_valid",    32'(out_valid),  32'(ev));
      chk("q_count",      32'(q_count),    32'(mq.size()));
      chk("out_pc",       out_pc,          epc);
      chk("out_pc_plus4", out_pc_plus4,    epc + 32'd4);
      chk("out_instr",    out_instr,       ein);
      chk("out_ecall",    32'(out_ecall),  32'(ev && ein == 32'h0000_0073));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_pc"},    out_pc,         32'd0);
      chk({tag, "_pc4"},   out_pc_plus4,   32'd4);
      chk({tag, "_instr"}, out_instr,      32'd0);
      chk({tag, "_ecall"}, 32'(out_ecall), 32'd0);
      chk({tag, "_count"}, 32'(q_count),   32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prev;
      logic [31:0] saved;
      int          since;
      bit          found;

      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      debug = 1'b1; boot_we = 1'b0; boot_addr = '0; boot_data = '0;
      model_reset();
      #12;
      chk_reset_outputs("reset");

      // Load words 0..255 through the boot port while fetch is halted.
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         boot_we   = 1'b1;
         boot_addr = IMEM_AW'(i);
         boot_data = (i < 4) ? 32'h0000_00A0 + 32'(i) : $urandom;
         cycle();
      end
      boot_we = 1'b0;

      // Fresh reset with fetch enabled: first entry after the second edge.
      #2; rst_n = 1'b0; #1;
      model_reset();
      debug = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();
      chk("boot_lat_edge1", 32'(out_valid), 32'd0);
      cycle();
      chk("boot_lat_edge2", 32'(out_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("boot_seq_pc",    out_pc,    32'(4*i));
         chk("boot_seq_instr", out_instr, 32'h0000_00A0 + 32'(i));
         if (i < 3) cycle();
      end

      // Back-pressure: queue saturates, then drains with no gaps.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      chk("full_count", 32'(q_count), 32'(QDEPTH));
      chk("full_head",  out_pc,       32'd12);
      out_ready = 1'b1;
      prev = 32'd12;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("drain_step", out_pc, prev + 32'd4);
         prev = out_pc;
      end

      // Redirect while three entries are queued and one read is in flight.
      redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b0;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      chk("pre_redirect_count", 32'(q_count), 32'd3);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      cycle();
      chk("flush_count", 32'(q_count),   32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      redirect_valid = 1'b0; out_ready = 1'b1;
      cycle();
      chk("bubble_valid", 32'(out_valid), 32'd0);
      cycle();
      chk("redir_valid", 32'(out_valid), 32'd1);
      chk("redir_pc",    out_pc,         32'h40);
      chk("redir_instr", out_instr,      mmem[16]);

      // Redirect coincident with the pop of PC 0x8.
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      cycle();
      redirect_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         found = out_valid && (out_pc == 32'h8);
      end
      chk("pop8_seen", 32'(found), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      cycle();
      chk("after_pop8_valid", 32'(out_valid), 32'd1);
      chk("after_pop8_pc",    out_pc,         32'h80);

      // Boot-written ECALL, and a write attempt outside debug.
      debug = 1'b1; boot_we = 1'b1; boot_addr = 13'd5; boot_data = 32'h0000_0073;
      cycle();
      debug = 1'b0; boot_addr = 13'd6; boot_data = ~mmem[6];
      saved = mmem[6];
      redirect_valid = 1'b1; redirect_pc = 32'h14;
      cycle();
      boot_we = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
      cycle();
      cycle();
      chk("ecall_pc",   out_pc,         32'h14);
      chk("ecall_flag", 32'(out_ecall), 32'd1);
      out_ready = 1'b1;
      cycle();
      chk("nodebug_write_pc",    out_pc,    32'h18);
      chk("nodebug_write_instr", out_instr, saved);

      // Asynchronous reset with two entries queued.
      redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("pre_areset_count", 32'(q_count), 32'd2);
      #2; rst_n = 1'b0; #1;
      chk_reset_outputs("areset");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      cycle();
      cycle();
      chk("restart_pc", out_pc, 32'h0);

      // Randomized traffic: back-pressure, redirects (incl. aliased PCs), debug.
      since = 0;
      for (int i = 0; i < 700; i++) begin
         out_ready      = ($urandom % 4) != 0;
         redirect_valid = (($urandom % 16) == 0) || (since >= 32);
         redirect_pc    = 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom % 4);
         if (($urandom % 8) == 0) redirect_pc = redirect_pc | 32'h0010_0000;
         debug          = ($urandom % 10) == 0;
         boot_we        = $urandom % 2;
         boot_addr      = IMEM_AW'($urandom_range(0, 255));
         boot_data      = $urandom;
         since          = redirect_valid ? 0 : since + 1;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
